// File: rtl/systolic_array_sequencer_if.sv
// Memory-side load bus of the systolic array sequencer: load requests in,
// per-row space flags and accepted-load strobes out.
interface systolic_array_sequencer_if #(
   parameter int unsigned ARRAY_DIM = 4
);
   localparam int unsigned RW = $clog2(ARRAY_DIM);

   logic                 weight_en;
   logic                 input_en;
   logic                 partial_en;
   logic [RW-1:0]        row_en;
   logic [ARRAY_DIM-1:0] fifo_has_space;
   logic [ARRAY_DIM-1:0] ps_has_space;
   logic                 weight_load;
   logic                 input_load;
   logic                 partials_load;
   logic [RW-1:0]        weight_row;
   logic [RW-1:0]        input_row;
   logic [RW-1:0]        partials_row;

   modport master (
      output weight_en, input_en, partial_en, row_en,
      input  fifo_has_space, ps_has_space,
      input  weight_load, input_load, partials_load,
      input  weight_row, input_row, partials_row
   );

   modport slave (
      input  weight_en, input_en, partial_en, row_en,
      output fifo_has_space, ps_has_space,
      output weight_load, input_load, partials_load,
      output weight_row, input_row, partials_row
   );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Control sequencer for the tensor-core systolic array: gates loads on FIFO space,
// steps the MAC array (with drain bubbles) and runs the partial-sum merge stage.
module systolic_array_sequencer #(
   parameter  int unsigned ARRAY_DIM  = 4,
   parameter  int unsigned MUL_LEN    = 2,
   parameter  int unsigned ADD_LEN    = 3,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned RW         = $clog2(ARRAY_DIM),
   localparam int unsigned MAC_LEN    = MUL_LEN + ADD_LEN,
   localparam int unsigned CW         = $clog2(MAC_LEN),
   localparam int unsigned AW         = $clog2(ADD_LEN),
   localparam int unsigned OW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   systolic_array_sequencer_if.slave ld,
   output logic [ARRAY_DIM-1:0]     in_fifo_shift,
   output logic [ARRAY_DIM-1:0]     ps_fifo_shift,
   output logic                     mac_start,
   output logic                     mac_shift,
   output logic [CW-1:0]            mac_count,
   output logic                     add_start,
   output logic                     out_fifo_shift,
   output logic [AW-1:0]            add_count,
   output logic [RW-1:0]            out_row,
   output logic                     weights_ready,
   output logic                     busy,
   output logic                     err
);

   typedef enum logic [1:0] {StIdle, StCompute, StAddWait, StAdd} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                mac_cnt_q, mac_cnt_d;
   logic [AW-1:0]                add_cnt_q, add_cnt_d;
   logic [ARRAY_DIM-1:0][OW-1:0] occ_q, occ_d;
   logic [ARRAY_DIM-1:0][OW-1:0] ps_occ_q, ps_occ_d;
   logic [ARRAY_DIM-1:0]         pipe_q, pipe_d;
   logic [ARRAY_DIM-1:0]         wmask_q, wmask_d;
   logic [RW-1:0]                out_row_q, out_row_d;
   logic                         err_q, err_d;
   logic                         popped_q, popped_d;

   logic [ARRAY_DIM-1:0] occ_nz, ps_nz, fifo_space, ps_space;
   logic [ARRAY_DIM-1:0] in_push, ps_push;
   logic                 weight_acc, input_acc, partial_acc, err_set;
   logic                 mac_last, add_last;

   always_comb begin
      for (int unsigned r = 0; r < ARRAY_DIM; r++) begin
         occ_nz[r]     = (occ_q[r] != '0);
         ps_nz[r]      = (ps_occ_q[r] != '0);
         fifo_space[r] = (occ_q[r] < OW'(FIFO_DEPTH));
         ps_space[r]   = (ps_occ_q[r] < OW'(FIFO_DEPTH));
      end
   end

   assign mac_last = (mac_cnt_q == CW'(MAC_LEN - 1));
   assign add_last = (add_cnt_q == AW'(ADD_LEN - 1));

   // Only the highest-priority request is considered; anything beneath it is dropped as an error.
   always_comb begin
      weight_acc  = 1'b0;
      input_acc   = 1'b0;
      partial_acc = 1'b0;
      err_set     = 1'b0;
      if (ld.weight_en) begin
         weight_acc = (state_q == StIdle);
         err_set    = !weight_acc || ld.input_en || ld.partial_en;
      end else if (ld.input_en) begin
         input_acc = fifo_space[ld.row_en];
         err_set   = !input_acc || ld.partial_en;
      end else if (ld.partial_en) begin
         partial_acc = ps_space[ld.row_en];
         err_set     = !partial_acc;
      end
   end

   assign ld.fifo_has_space = fifo_space;
   assign ld.ps_has_space   = ps_space;
   assign ld.weight_load    = weight_acc;
   assign ld.input_load     = input_acc;
   assign ld.partials_load  = partial_acc;
   assign ld.weight_row     = ld.row_en;
   assign ld.input_row      = ld.row_en;
   assign ld.partials_row   = ld.row_en;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state; with a partial already waiting the merge starts without an ADD_WAIT cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (weights_ready && (|occ_nz || |pipe_q)) state_d = StCompute;
         end
         StCompute: begin
            if (mac_last) begin
               if (!pipe_q[ARRAY_DIM-1])  state_d = StIdle;
               else if (ps_nz[out_row_q]) state_d = StAdd;
               else                       state_d = StAddWait;
            end
         end
         StAddWait: begin
            if (ps_nz[out_row_q]) state_d = StAdd;
         end
         StAdd: begin
            if (add_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      mac_start      = (state_q == StCompute) && (mac_cnt_q == '0);
      mac_shift      = (state_q == StCompute) && mac_last;
      in_fifo_shift  = mac_start ? occ_nz : '0;
      add_start      = (state_q == StAdd) && (add_cnt_q == '0);
      out_fifo_shift = (state_q == StAdd) && add_last;
      ps_fifo_shift  = '0;
      ps_fifo_shift[out_row_q] = add_start;
      mac_count      = mac_cnt_q;
      add_count      = add_cnt_q;
      out_row        = out_row_q;
      weights_ready  = &wmask_q;
      busy           = (state_q != StIdle);
      err            = err_q;
   end

   // Datapath next-state: counters, occupancies, pipe, weight mask
   always_comb begin
      mac_cnt_d = (state_q == StCompute && !mac_last) ? mac_cnt_q + CW'(1) : '0;
      add_cnt_d = (state_q == StAdd && !add_last) ? add_cnt_q + AW'(1) : '0;

      in_push = '0;
      ps_push = '0;
      in_push[ld.row_en] = input_acc;
      ps_push[ld.row_en] = partial_acc;

      occ_d    = occ_q;
      ps_occ_d = ps_occ_q;
      for (int unsigned r = 0; r < ARRAY_DIM; r++) begin
         if (in_push[r] && !in_fifo_shift[r])      occ_d[r] = occ_q[r] + OW'(1);
         else if (!in_push[r] && in_fifo_shift[r]) occ_d[r] = occ_q[r] - OW'(1);
         if (ps_push[r] && !ps_fifo_shift[r])      ps_occ_d[r] = ps_occ_q[r] + OW'(1);
         else if (!ps_push[r] && ps_fifo_shift[r]) ps_occ_d[r] = ps_occ_q[r] - OW'(1);
      end

      popped_d = mac_start ? |in_fifo_shift : popped_q;
      pipe_d   = mac_shift ? {pipe_q[ARRAY_DIM-2:0], popped_q} : pipe_q;

      wmask_d = wmask_q;
      if (weight_acc) wmask_d[ld.row_en] = 1'b1;

      out_row_d = out_row_q;
      if (out_fifo_shift) begin
         out_row_d = (out_row_q == RW'(ARRAY_DIM - 1)) ? '0 : out_row_q + RW'(1);
      end

      err_d = err_q | err_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_cnt_q <= '0;
         add_cnt_q <= '0;
         occ_q     <= '0;
         ps_occ_q  <= '0;
         pipe_q    <= '0;
         wmask_q   <= '0;
         out_row_q <= '0;
         err_q     <= 1'b0;
         popped_q  <= 1'b0;
      end else begin
         mac_cnt_q <= mac_cnt_d;
         add_cnt_q <= add_cnt_d;
         occ_q     <= occ_d;
         ps_occ_q  <= ps_occ_d;
         pipe_q    <= pipe_d;
         wmask_q   <= wmask_d;
         out_row_q <= out_row_d;
         err_q     <= err_d;
         popped_q  <= popped_d;
      end
   end

endmodule
